// File: rtl/alu_divider_seq_pkg.sv
// Shared ALU/divider definitions: ALU function codes, divider state encoding, width.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DIV_WIDTH = 32;

    // ALU function codes, shared with the ALU and the ALU control decoder
    localparam logic [5:0] ALU_ADD = 6'd32;
    localparam logic [5:0] ALU_SUB = 6'd34;
    localparam logic [5:0] ALU_AND = 6'd36;
    localparam logic [5:0] ALU_OR  = 6'd37;
    localparam logic [5:0] ALU_SLT = 6'd42;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ITER = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/alu_divider_seq_if.sv
// Divider request/result bus plus the ALU operand/function/result bus.
// Latency: n/a (wiring only); alu_result returns combinationally in the same cycle.
// Backpressure: none; start is only honoured while the divider is not iterating.
// Ports: master = divider side (drives busy/done/results and ALU operands),
//        slave  = core/ALU side (drives start/operands and alu_result).
interface alu_divider_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [5:0]       alu_signal;
    logic [WIDTH-1:0] alu_result;

    modport master (
        input  start, dividend, divisor, alu_result,
        output busy, done, quotient, remainder, alu_a, alu_b, alu_signal
    );

    modport slave (
        output start, dividend, divisor, alu_result,
        input  busy, done, quotient, remainder, alu_a, alu_b, alu_signal
    );
endinterface

// File: rtl/alu_divider_seq_div_step.sv
// One restoring-division step: shift R:Q left, decide subtract, pick next R and Q.
// Latency: combinational.
// Backpressure: n/a.
// Ports: r_i/q_i/d_i current state, alu_result_i = S - D from the ALU;
//        s_o shifted partial remainder, ge_o quotient bit, r_next_o/q_next_o next state.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [WIDTH-1:0] alu_result_i,
    output logic [WIDTH-1:0] s_o,
    output logic             ge_o,
    output logic [WIDTH-1:0] r_next_o,
    output logic [WIDTH-1:0] q_next_o
);
    logic carry;

    assign s_o   = {r_i[WIDTH-2:0], q_i[WIDTH-1]};
    // The bit shifted out of R is the 33rd bit of the partial remainder; when
    // set, S exceeds D regardless of the low 32 bits.
    assign carry = r_i[WIDTH-1];
    // Unsigned compare done locally: the ALU SLT is signed.
    assign ge_o  = carry | (s_o >= d_i);
    // Low bits of the ALU difference are exact even when carry is set.
    assign r_next_o = ge_o ? alu_result_i : s_o;
    assign q_next_o = {q_i[WIDTH-2:0], ge_o};
endmodule

// File: rtl/alu_divider_seq.sv
// Iterative unsigned divider (DIVU) that borrows the datapath ALU for its subtracts.
// Latency: done 33 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: start ignored while busy; accepted in IDLE or in the DONE cycle.
// Ports: clk, reset (sync, active-high), bus = divider master side of the request/ALU bus.
module alu_divider_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    alu_divider_seq_if.master  bus
);
    localparam logic [1:0] IDLE = DIV_IDLE;
    localparam logic [1:0] ITER = DIV_ITER;
    localparam logic [1:0] DONE = DIV_DONE;
    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [4:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;
    // ge is already folded into step_q; nothing else in the top needs it.
    logic             step_ge_unused;
    logic             accept;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i          (r_q),
        .q_i          (q_q),
        .d_i          (d_q),
        .alu_result_i (bus.alu_result),
        .s_o          (step_s),
        .ge_o         (step_ge_unused),
        .r_next_o     (step_r),
        .q_next_o     (step_q)
    );

    assign accept = bus.start && (state_q != ITER);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;

        case (state_q)
            ITER: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CNT_LAST) begin
                    quo_d   = step_q;
                    rem_d   = step_r;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A start in DONE overrides the return to IDLE for back-to-back use.
        if (accept) begin
            q_d   = bus.dividend;
            r_d   = '0;
            d_d   = bus.divisor;
            cnt_d = '0;
            if (bus.divisor == '0) begin
                quo_d   = '1;
                rem_d   = bus.dividend;
                state_d = DONE;
            end else begin
                state_d = ITER;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy       = (state_q == ITER);
    assign bus.done       = (state_q == DONE);
    assign bus.quotient   = quo_q;
    assign bus.remainder  = rem_q;
    // ALU operands come from registered state only, so the ALU round trip
    // through alu_result has no combinational loop.
    assign bus.alu_a      = (state_q == ITER) ? step_s : '0;
    assign bus.alu_b      = (state_q == ITER) ? d_q : '0;
    assign bus.alu_signal = (state_q == ITER) ? ALU_SUB : ALU_ADD;
endmodule
